// File: rtl/serial_sub_pkg.sv
// Shared constants for the bit-serial subtractor: FSM state encoding and default operand width.
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/serial_sub_if.sv
// Operand/result handshake bundle for serial_sub: requester drives start/a/b, the subtractor returns busy/done/diff/borrow.
interface serial_sub_if
#(
    parameter int WIDTH = serial_sub_pkg::DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow
    );
endinterface

// File: rtl/serial_sub_fullsub.sv
// Combinational full subtractor (a - b - bin) from two chained half-subtractor cells.
module serial_sub_fullsub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    logic w_d1;
    logic w_b1;
    logic w_b2;

    // first cell computes a - b, second subtracts the incoming borrow from that partial difference
    assign w_d1 = a ^ b;
    assign w_b1 = ~a & b;
    assign d    = w_d1 ^ bin;
    assign w_b2 = ~w_d1 & bin;
    assign bout = w_b1 | w_b2;
endmodule

// File: rtl/serial_sub.sv
// Bit-serial a - b, LSB first, one bit per clock: done pulses WIDTH cycles after the start edge.
// No backpressure; start is ignored while busy or done, so throughput is one op per WIDTH+2 cycles.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    serial_sub_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_sr;
    logic             r_bq;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;

    logic             w_d;
    logic             w_bout;

    serial_sub_fullsub u_fullsub (
        .a    (r_sa[0]),
        .b    (r_sb[0]),
        .bin  (r_bq),
        .d    (w_d),
        .bout (w_bout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_sa     <= '0;
            r_sb     <= '0;
            r_sr     <= '0;
            r_bq     <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_sa    <= bus.a;
                        r_sb    <= bus.b;
                        r_sr    <= '0;
                        r_bq    <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_sa <= r_sa >> 1;
                    r_sb <= r_sb >> 1;
                    r_sr <= {w_d, r_sr[WIDTH-1:1]};
                    r_bq <= w_bout;
                    // the last bit goes straight into the result register alongside the shifted partials
                    if (r_cnt == LAST_BIT) begin
                        r_diff   <= {w_d, r_sr[WIDTH-1:1]};
                        r_borrow <= w_bout;
                        r_state  <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = (r_state == ST_RUN);
    assign bus.done   = (r_state == ST_DONE);
    assign bus.diff   = r_diff;
    assign bus.borrow = r_borrow;
endmodule

// File: tb/tb_serial_sub.sv
// Randomized scoreboard bench for serial_sub: driver queues expected results, a negedge monitor checks timing and values.
module tb_serial_sub;
    import serial_sub_pkg::*;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] diff;
        logic         borrow;
        int           k;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc     = 0;
    int   n_pass  = 0;
    int   n_total = 0;
    bit   chk_en  = 0;

    exp_t         q[$];
    logic [W-1:0] last_diff   = '0;
    logic         last_borrow = 1'b0;

    serial_sub_if #(.WIDTH(W)) bus ();

    serial_sub #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    // Reference: plain unsigned arithmetic on the operands, with done due WIDTH edges after acceptance.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int k);
        exp_t e;
        int   d;
        d        = int'(a) - int'(b);
        e.diff   = d[W-1:0];
        e.borrow = (a < b);
        e.k      = k;
        return e;
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (chk_en) begin
            bit   exp_busy;
            bit   exp_done;
            exp_t e;
            exp_busy = 1'b0;
            exp_done = 1'b0;
            if (q.size() > 0) begin
                if (cyc - q[0].k < W)  exp_busy = 1'b1;
                if (cyc - q[0].k == W) exp_done = 1'b1;
            end
            check("busy", 32'(bus.busy), 32'(exp_busy));
            check("done", 32'(bus.done), 32'(exp_done));
            if (exp_done) begin
                e           = q.pop_front();
                last_diff   = e.diff;
                last_borrow = e.borrow;
            end
            check("diff", 32'(bus.diff), 32'(last_diff));
            check("borrow", 32'(bus.borrow), 32'(last_borrow));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues start on the next edge and returns at the cycle before the earliest possible next accept.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        tick();
        q.push_back(model(a, b, cyc));
        if (!hold) bus.start = 1'b0;
        bus.a = W'($urandom);
        bus.b = W'($urandom);
        repeat (W + 1) tick();
    endtask

    initial begin
        bit hold;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        rst    = 1'b0;
        tick();

        run_op(8'h09, 8'h05, 1'b0);
        tick();
        run_op(8'h05, 8'h09, 1'b0);
        run_op(8'h00, 8'h01, 1'b0);
        tick();

        // back-to-back with start held high
        run_op(8'hFF, 8'hFF, 1'b1);
        run_op(8'h00, 8'h00, 1'b0);
        tick();

        // start pulsed mid-run with new operands must be ignored
        bus.start = 1'b1;
        bus.a     = 8'h3C;
        bus.b     = 8'hC3;
        tick();
        q.push_back(model(8'h3C, 8'hC3, cyc));
        bus.start = 1'b0;
        repeat (2) tick();
        bus.start = 1'b1;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        tick();
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        repeat (W - 2) tick();
        tick();

        // reset mid-run discards the operation and clears outputs
        bus.start = 1'b1;
        bus.a     = 8'h77;
        bus.b     = 8'h11;
        tick();
        q.push_back(model(8'h77, 8'h11, cyc));
        bus.start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        q.delete();
        last_diff   = '0;
        last_borrow = 1'b0;
        rst         = 1'b0;
        tick();
        run_op(8'hA0, 8'h3C, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            hold = (i < 999) ? 1'($urandom_range(0, 1)) : 1'b0;
            run_op(W'($urandom), W'($urandom), hold);
            if (!hold) repeat ($urandom_range(0, 2)) tick();
        end

        repeat (3) tick();
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/serial_sub.md
# serial_sub

Bit-serial subtractor: computes a − b for two WIDTH-bit unsigned operands one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop. It is the inverse-direction companion of the combinational half-adder cell and the sequential building block for area-constrained arithmetic paths. It uses a start/busy/done handshake, and the result holds until the next start.

## Interface
- WIDTH, default 8: operand and result width in bits; legal range ≥ 2.
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; sampled on the start edge only.
- b  input  WIDTH  subtrahend; sampled on the start edge only.
- busy  output  1  high while the operation is in progress (RUN).
- done  output  1  one-cycle pulse; diff and borrow are valid from this cycle on.
- diff  output  WIDTH  (a − b) mod 2^WIDTH.
- borrow  output  1  final borrow out; 1 iff a < b (unsigned).

## Operation
- State machine with three states:
  - IDLE → RUN on start=1.
  - RUN → DONE after WIDTH bit steps.
  - DONE → IDLE unconditionally after one cycle.
- On the start edge in IDLE:
  - load shift registers sa←a and sb←b.
  - clear the internal borrow flip-flop bq←0.
  - clear the bit counter cnt←0.
  - clear the internal result shift register sr.
- Each RUN edge processes bit i = cnt:
  - d = sa[0] ^ sb[0] ^ bq.
  - bout = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bq).
  - sa and sb shift right by one; d shifts into the MSB of sr; bq←bout; cnt←cnt+1.
- When cnt reaches WIDTH−1, the same edge moves to DONE and loads diff←{d, sr[WIDTH-1:1]} and borrow←bout.
- cnt width is clog2(WIDTH); it never wraps past WIDTH−1.
- diff and borrow change only on the RUN→DONE edge. They hold the previous result throughout the next RUN and hold indefinitely in IDLE.
- start is ignored in RUN and DONE; it is not queued. start held high continuously restarts the block in the first IDLE cycle after DONE, using the a and b values present on that edge.
- a and b may change freely after the start edge without affecting the result.

## Timing
- Reset values:
  - Outputs: busy=0, done=0, diff=0, borrow=0.
  - Internal: state=IDLE, cnt=0, bq=0, sa=sb=sr=0.
- Reset takes priority over every other action, including mid-RUN and in DONE. The block is in IDLE on the cycle after rst is sampled high, and any in-flight result is discarded.
- Let E0 be the edge where start is sampled in IDLE:
  - busy is high for exactly WIDTH cycles, from after E0 to edge E_WIDTH.
  - done is high for exactly one cycle, between E_WIDTH and E_WIDTH+1; busy=0 during that cycle.
  - The next start is accepted at E_WIDTH+2 at the earliest. Throughput is one operation per WIDTH+2 cycles.
- busy and done are registered state decodes, so no combinational path runs from inputs to outputs.

## Structure
- Shared package/header holds:
  - state encoding localparams: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2. The value 2'd3 is illegal and must recover to IDLE.
  - the default WIDTH constant.
- One sub-module, fullsub: a combinational full subtractor built from two half-subtractor cells, with ports a, b, bin, d, bout. It is instantiated once in serial_sub.
- serial_sub contains the FSM, counter, shift registers, borrow flip-flop and output registers.

## Test plan
- Reset, then WIDTH=8, a=8'h09, b=8'h05, one start pulse → busy high 8 cycles, then done 1 cycle with diff=8'h04, borrow=0.
- a=8'h05, b=8'h09 → diff=8'hFC, borrow=1. Then a=8'h00, b=8'h01 → diff=8'hFF, borrow=1.
- Edge operands with back-to-back starts (start held high):
  - a=b=8'hFF → diff=8'h00, borrow=0.
  - a=b=8'h00 → diff=8'h00, borrow=0.
  - Second done arrives exactly 10 cycles after the first.
- Pulse start again at RUN cycle 3 while changing a and b mid-run → ignored; result matches the originally latched operands, and diff holds the prior result until done.
- Assert rst at RUN cycle 4 → all outputs 0 on the next cycle and no done pulse follows. A fresh start then computes 8'hA0 − 8'h3C = 8'h64, borrow=0.
- Random sweep of 1000 operand pairs → every done matches diff=(a−b)&8'hFF and borrow=(a<b), and the busy/done timing is exact per operation.
